irq_priority_arbiter: RTL and testbench
=======================================

# irq_priority_arbiter

Multi-source interrupt arbiter that sits in front of the core's interrupt controller and drives its single interrupt request line. It captures rising edges on N external interrupt lines into pending bits and applies a per-source enable mask. It picks one winner, holds the request until the controller takes the trap, then waits for the trap-return pulse before retiring that source. It also supplies the mcause value and source ID for the trap currently in service.

## Interface
- N_SRC, 16, number of interrupt sources; legal range 2..32
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- irq_lines_i  in  N_SRC  raw interrupt lines, already synchronous to clk_i; rising edge = event
- mask_i  in  N_SRC  per-source enable (1 = enabled), driven from CSR logic
- irq_taken_i  in  1  one-cycle pulse: controller entered the trap for the current request
- irq_ret_i  in  1  one-cycle pulse: controller executed mret for an interrupt
- irq_req_o  out  1  request to controller (registered)
- irq_id_o  out  5  index of latched winner (registered)
- irq_cause_o  out  32  32'h1000_0000 + 16 + irq_id_o (combinational from irq_id_o)
- busy_o  out  1  high in REQ or SERVICE
- pending_o  out  N_SRC  pending bit vector (for CSR readback)

## Operation
- Edge capture: register prev[i]; pending[i] set when irq_lines_i[i] & ~prev[i]. Pending is cleared only by retirement; a new edge on an already-pending source is absorbed (no counting).
- Candidates = pending & mask_i. Masked pending bits stay pending and become eligible when unmasked.
- FSM states:
  - IDLE: if candidates ≠ 0, latch the winner into irq_id_o and go to REQ. Otherwise stay.
  - REQ: irq_req_o = 1.
    - irq_taken_i → SERVICE.
    - If mask_i[id] drops while irq_taken_i is low → IDLE (withdraw). Pending is kept.
    - irq_taken_i and a mask drop in the same cycle: taken wins.
  - SERVICE: irq_req_o = 0. On irq_ret_i, clear pending[id] and go to IDLE.
- Retirement vs. new edge: if a new edge on source id arrives in the same cycle as irq_ret_i, the set wins and pending[id] stays 1.
- Winner selection (default): fixed priority, lowest index wins.
- The winner is frozen while in REQ or SERVICE. A higher-priority arrival waits until the next IDLE; there is no preemption.
- irq_taken_i outside REQ and irq_ret_i outside SERVICE are ignored.
- Reset values:
  - prev = 0, pending = 0, state = IDLE.
  - irq_req_o = 0, irq_id_o = 0, busy_o = 0; hence irq_cause_o = 32'h1000_0010.
  - Because prev resets to 0, a line already high when reset releases is captured as one edge.
- Reset asserted mid-operation (REQ or SERVICE) discards all pending bits and returns to IDLE on the next edge.

## Timing
- Edge sampled at cycle t → pending set at t+1 → state REQ with irq_req_o = 1 and irq_id_o valid at t+2.
- irq_taken_i at cycle t → irq_req_o = 0 at t+1.
- irq_ret_i at cycle t → pending[id] cleared and state IDLE at t+1. The next winner's irq_req_o goes high at t+2.
- Minimum spacing between two back-to-back requests is 2 cycles after retirement.
- All outputs except irq_cause_o are registered.

## Configuration
- IRQ_ARB_ROUND_ROBIN_EN defined: rotating priority.
  - Register rr_ptr resets to 0. After each retirement of source k, rr_ptr = (k+1) mod N_SRC.
  - The search starts at rr_ptr and wraps through N_SRC-1 to 0.
  - A withdrawal does not move rr_ptr.
- Undefined: fixed priority, lowest index wins, and no rr_ptr register exists.

## Test plan
- Single source: N_SRC=16, mask=16'hFFFF, rising edge on line 3 at cycle 10.
  - Required: irq_req_o=1, irq_id_o=3, irq_cause_o=32'h1000_0013 at cycle 12.
  - irq_taken_i pulse → req low next cycle.
  - irq_ret_i → pending_o[3]=0.
- Simultaneous edges on lines 5 and 2 (fixed priority).
  - Required: id 2 served first.
  - After its irq_ret_i, id 5 requested 2 cycles later.
  - With IRQ_ARB_ROUND_ROBIN_EN, lines 2 and 5 re-fired while 5 is serviced: next winner is 2 only if no pending source exists in 6..15.
- Masked source: edge on line 7 with mask_i[7]=0.
  - Required: no request; pending_o[7]=1.
  - Set mask_i[7]=1: irq_req_o high 1 cycle later with id 7.
- Withdrawal: in REQ for id 4, drop mask_i[4] with irq_taken_i low.
  - Required: irq_req_o=0 next cycle, state IDLE, pending_o[4] still 1.
- Re-arm race: new edge on line 1 in the same cycle as irq_ret_i for id 1.
  - Required: pending_o[1] stays 1 and id 1 is requested again.
- Reset in SERVICE with pending 16'h00A0.
  - Required: after rst_i, pending_o=0, irq_req_o=0, busy_o=0, irq_cause_o=32'h1000_0010.

Source files
------------

// File: rtl/irq_priority_arbiter.sv
// Interrupt arbiter: rising-edge capture into pending bits, masked winner select, REQ/SERVICE handshake.
// Optional IRQ_ARB_ROUND_ROBIN_EN: rotating priority from rr_ptr; default is fixed priority, lowest index wins.
module irq_priority_arbiter #(
  parameter int N_SRC = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_lines_i,
  input  logic [N_SRC-1:0] mask_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [4:0]       irq_id_o,
  output logic [31:0]      irq_cause_o,
  output logic             busy_o,
  output logic [N_SRC-1:0] pending_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  state_t           state_q;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] retire_vec;
  logic [31:0]      cand_w;
  logic [31:0]      mask_w;
  logic [4:0]       search_start;
  logic [4:0]       winner;
  logic             found;
  logic [5:0]       sel_idx;
  logic             retire;
  logic             irq_req_q;
  logic [4:0]       irq_id_q;
  logic             busy_q;

  assign retire = (state_q == S_SVC) && irq_ret_i;
  assign cand_w = 32'(pending_q & mask_i);
  assign mask_w = 32'(mask_i);

  // A fresh edge in the retirement cycle re-arms the source: set wins over clear.
  assign retire_vec = retire ? (N_SRC'(1) << irq_id_q) : '0;
  assign pending_d  = (pending_q & ~retire_vec) | (irq_lines_i & ~prev_q);

`ifdef IRQ_ARB_ROUND_ROBIN_EN
  logic [4:0] rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (retire) begin
      if (int'(irq_id_q) == N_SRC - 1) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= irq_id_q + 5'd1;
      end
    end
  end

  assign search_start = rr_ptr_q;
`else
  assign search_start = '0;
`endif

  // Circular search from search_start; first eligible source wins.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    sel_idx = '0;
    for (int off = 0; off < N_SRC; off++) begin
      sel_idx = {1'b0, search_start} + 6'(off);
      if (sel_idx >= 6'(N_SRC)) begin
        sel_idx = sel_idx - 6'(N_SRC);
      end
      if (!found && cand_w[sel_idx[4:0]]) begin
        found  = 1'b1;
        winner = sel_idx[4:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      prev_q    <= irq_lines_i;
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            irq_id_q  <= winner;
            irq_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_taken_i) begin
            irq_req_q <= 1'b0;
            state_q   <= S_SVC;
          end else if (!mask_w[irq_id_q]) begin
            irq_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_SVC: begin
          if (irq_ret_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          irq_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign irq_req_o   = irq_req_q;
  assign irq_id_o    = irq_id_q;
  assign busy_o      = busy_q;
  assign pending_o   = pending_q;
  assign irq_cause_o = 32'h1000_0010 + {27'b0, irq_id_q};

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Randomized bench for irq_priority_arbiter with an array-based reference model and directed anchors.
module tb_irq_priority_arbiter;
  localparam int N = 16;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] lines;
  logic [N-1:0] mask;
  logic         taken;
  logic         ret;
  logic         irq_req;
  logic [4:0]   irq_id;
  logic [31:0]  irq_cause;
  logic         busy;
  logic [N-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in service.
  bit m_pend [N];
  bit m_prev [N];
  bit m_nxt  [N];
  int m_phase;
  int m_id;
  int m_rr;
  int m_w;
  int m_j;

  irq_priority_arbiter #(.N_SRC(N)) dut (
    .clk_i(clk), .rst_i(rst), .irq_lines_i(lines), .mask_i(mask),
    .irq_taken_i(taken), .irq_ret_i(ret), .irq_req_o(irq_req), .irq_id_o(irq_id),
    .irq_cause_o(irq_cause), .busy_o(busy), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_phase = 0;
      m_id    = 0;
      m_rr    = 0;
    end else begin
      for (int i = 0; i < N; i++) m_nxt[i] = m_pend[i];
      if (m_phase == 2 && ret) m_nxt[m_id] = 1'b0;
      for (int i = 0; i < N; i++) if (lines[i] && !m_prev[i]) m_nxt[i] = 1'b1;
      case (m_phase)
        0: begin
          m_w = -1;
          for (int k = 0; k < N; k++) begin
            m_j = (m_rr + k) % N;
            if (m_w < 0 && m_pend[m_j] && mask[m_j]) m_w = m_j;
          end
          if (m_w >= 0) begin
            m_id    = m_w;
            m_phase = 1;
          end
        end
        1: begin
          if (taken) m_phase = 2;
          else if (!mask[m_id]) m_phase = 0;
        end
        default: begin
          if (ret) begin
            m_phase = 0;
            if (RR_ON) m_rr = (m_id + 1) % N;
          end
        end
      endcase
      for (int i = 0; i < N; i++) begin
        m_pend[i] = m_nxt[i];
        m_prev[i] = lines[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] ep;
      for (int i = 0; i < N; i++) ep[i] = m_pend[i];
      chk("model_req", 32'(irq_req), 32'(m_phase == 1));
      chk("model_busy", 32'(busy), 32'(m_phase != 0));
      chk("model_id", 32'(irq_id), 32'(m_id));
      chk("model_cause", irq_cause, 32'h1000_0010 + 32'(m_id));
      chk("model_pending", 32'(pending), 32'(ep));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve();
    taken = 1'b1;
    tick();
    taken = 1'b0;
    ret = 1'b1;
    tick();
    ret = 1'b0;
  endtask

  initial begin
    logic [4:0] first_id;
    rst = 1'b1; lines = '0; mask = '1; taken = 1'b0; ret = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cause", irq_cause, 32'h1000_0010);
    chk("rst_pending", 32'(pending), 32'd0);

    // Single source on line 3
    lines[3] = 1'b1;
    tick();
    chk("single_pend", 32'(pending), 32'h0008);
    chk("single_req_early", 32'(irq_req), 32'd0);
    tick();
    chk("single_req", 32'(irq_req), 32'd1);
    chk("single_id", 32'(irq_id), 32'd3);
    chk("single_cause", irq_cause, 32'h1000_0013);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk("single_taken_req", 32'(irq_req), 32'd0);
    chk("single_taken_busy", 32'(busy), 32'd1);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    lines = '0;
    chk("single_ret_pend", 32'(pending), 32'd0);
    chk("single_ret_busy", 32'(busy), 32'd0);

    // Simultaneous edges on 5 and 2
    first_id = RR_ON ? 5'd5 : 5'd2;
    lines = 16'h0024;
    tick();
    tick();
    lines = '0;
    chk("simul_first_id", 32'(irq_id), 32'(first_id));
    chk("simul_first_req", 32'(irq_req), 32'd1);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("simul_gap_req", 32'(irq_req), 32'd0);
    tick();
    chk("simul_second_req", 32'(irq_req), 32'd1);
    chk("simul_second_id", 32'(irq_id), RR_ON ? 32'd2 : 32'd5);
    serve();

    // Masked source 7
    mask[7] = 1'b0;
    lines[7] = 1'b1;
    tick(); tick(); tick();
    chk("mask_no_req", 32'(irq_req), 32'd0);
    chk("mask_pend", 32'(pending), 32'h0080);
    mask[7] = 1'b1;
    tick();
    chk("unmask_req", 32'(irq_req), 32'd1);
    chk("unmask_id", 32'(irq_id), 32'd7);
    lines = '0;
    serve();

    // Withdrawal of source 4
    lines[4] = 1'b1;
    tick(); tick();
    chk("wd_req", 32'(irq_req), 32'd1);
    chk("wd_id", 32'(irq_id), 32'd4);
    mask[4] = 1'b0;
    tick();
    chk("wd_req_low", 32'(irq_req), 32'd0);
    chk("wd_busy_low", 32'(busy), 32'd0);
    chk("wd_pend_kept", 32'(pending), 32'h0010);
    mask = '1;
    lines = '0;
    tick();
    chk("wd_rereq", 32'(irq_req), 32'd1);
    serve();

    // Re-arm race on source 1
    lines[1] = 1'b1;
    tick(); tick();
    lines[1] = 1'b0;
    chk("rearm_id", 32'(irq_id), 32'd1);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    ret = 1'b1;
    lines[1] = 1'b1;
    tick();
    ret = 1'b0;
    chk("rearm_pend", 32'(pending), 32'h0002);
    chk("rearm_busy", 32'(busy), 32'd0);
    tick();
    chk("rearm_req", 32'(irq_req), 32'd1);
    chk("rearm_id2", 32'(irq_id), 32'd1);
    lines = '0;
    serve();

    // Reset while in service with pending 0x00A0
    lines = 16'h00A0;
    tick(); tick();
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk("svc_pend", 32'(pending), 32'h00A0);
    chk("svc_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_svc_pend", 32'(pending), 32'd0);
    chk("rst_svc_req", 32'(irq_req), 32'd0);
    chk("rst_svc_busy", 32'(busy), 32'd0);
    chk("rst_svc_cause", irq_cause, 32'h1000_0010);
    tick();
    chk("rst_high_line_edge", 32'(pending), 32'h00A0);
    lines = '0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) lines[i] = ~lines[i];
      if ($urandom_range(0, 19) == 0) mask[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) mask = '1;
      taken = (m_phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      ret   = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; taken = 1'b0; ret = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
